dcache_ctrl: RTL and testbench

//  Responder end of the processor<->cache request interface: accepts load/store requests (valid, rw,

---
 rtl/dcache_ctrl_pkg.sv | 22 ++
 rtl/dcache_ctrl_if.sv | 32 +++
 rtl/dcache_ctrl_line_array.sv | 45 ++++
 rtl/dcache_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and default geometry for the direct-mapped, write-through data cache.
package dcache_ctrl_pkg;

  localparam int DC_ADDR_W  = 12;
  localparam int DC_DATA_W  = 8;
  localparam int DC_INDEX_W = 6;
  localparam int DC_TAG_W   = DC_ADDR_W - DC_INDEX_W;

  typedef enum logic {
    OP_STORE = 1'b0,
    OP_LOAD  = 1'b1
  } dc_opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
  } dcache_state_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Processor request/response and backing-memory handshake bundle for dcache_ctrl.
interface dcache_ctrl_if import dcache_ctrl_pkg::*; #(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W
);

  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] address_cache;
  logic              hit;
  logic              gnt;
  logic              busy;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // master = processor plus memory model; slave = the cache controller
  modport master (
    output valid, rw, address_cache, mem_rdata, mem_ack,
    input  hit, gnt, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  valid, rw, address_cache, mem_rdata, mem_ack,
    output hit, gnt, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_ctrl_line_array.sv
// Tag/data/valid storage for dcache_ctrl: one async read port, one write port.
// Only the valid bits are reset, so a reset invalidates every line at once.
module dcache_line_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_bits;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (we) begin
      valid_bits[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_bits[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate byte cache between a processor and a req/ack memory.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl import dcache_ctrl_pkg::*; #(
  parameter int ADDR_W  = DC_ADDR_W,
  parameter int DATA_W  = DC_DATA_W,
  parameter int INDEX_W = DC_INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  dcache_ctrl_if.slave        bus,
  inout  wire  [DATA_W-1:0]   data_cache
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  dcache_state_t     state;
  logic [ADDR_W-1:0] addr_q;
  dc_opcode_t        rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hit_q;
  logic              gnt_q;

  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               lookup_hit;
  logic               arr_we;
  logic [DATA_W-1:0]  arr_wr_data;

  assign idx_q      = addr_q[INDEX_W-1:0];
  assign tag_q      = addr_q[ADDR_W-1:INDEX_W];
  assign lookup_hit = line_valid && (line_tag == tag_q);

  dcache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_q),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (arr_we),
    .wr_idx   (idx_q),
    .wr_tag   (tag_q),
    .wr_data  (arr_wr_data)
  );

  // Store hits update the line during LOOKUP; load misses allocate when the refill arrives.
  always_comb begin
    arr_we      = 1'b0;
    arr_wr_data = wdata_q;
    if (state == LOOKUP && rw_q == OP_STORE && lookup_hit) begin
      arr_we = 1'b1;
    end else if (state == MEM_RD && bus.mem_ack) begin
      arr_we      = 1'b1;
      arr_wr_data = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      rw_q          <= OP_STORE;
      wdata_q       <= '0;
      hit_q         <= 1'b0;
      gnt_q         <= 1'b0;
      bus.gnt       <= 1'b0;
      bus.hit       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      gnt_q <= bus.gnt;
      case (state)
        IDLE: begin
          // gnt_q forces an idle cycle after every grant so a held valid is not re-accepted
          if (bus.valid && !gnt_q) begin
            addr_q <= bus.address_cache;
            rw_q   <= dc_opcode_t'(bus.rw);
            if (!bus.rw) begin
              wdata_q <= data_cache;
            end
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= lookup_hit;
          if (rw_q == OP_LOAD && lookup_hit) begin
            state   <= RESP;
            bus.gnt <= 1'b1;
            bus.hit <= 1'b1;
          end else if (rw_q == OP_LOAD) begin
            state        <= MEM_RD;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= addr_q;
          end else begin
            state         <= MEM_WR;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= wdata_q;
          end
        end
        MEM_RD: begin
          if (bus.mem_ack) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
            bus.gnt     <= 1'b1;
            bus.hit     <= 1'b0;
          end
        end
        MEM_WR: begin
          if (bus.mem_ack) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.gnt     <= 1'b1;
            bus.hit     <= hit_q;
          end
        end
        RESP: begin
          state   <= IDLE;
          bus.gnt <= 1'b0;
          bus.hit <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign data_cache = (state == RESP && rw_q == OP_LOAD) ? line_data : {DATA_W{1'bz}};

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (hit_q) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then random loads/stores against
// an address-level cache model and a flat byte-array memory.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  wire  [7:0] data_cache;
  logic [7:0] tb_wdata;
  logic       tb_drive;
  assign data_cache = tb_drive ? tb_wdata : 8'bz;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .data_cache (data_cache)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Model: backing memory as a byte array; each line remembers which full address it holds.
  logic [7:0]  mem_model [4096];
  bit          line_ok   [64];
  logic [11:0] line_addr [64];
  logic [7:0]  line_byte [64];

  int num_vectors;
  int num_miscompares;
  int exp_hits;
  int exp_misses;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 64; i++) line_ok[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic resetDut();
    rst               = 1'b1;
    bus.valid         = 1'b0;
    bus.rw            = 1'b0;
    bus.address_cache = '0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    tb_drive          = 1'b0;
    tb_wdata          = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  // One complete transaction; early=1 raises valid during the post-grant hold-off cycle.
  task automatic applyStimulus(input bit is_load, input logic [11:0] addr, input logic [7:0] sdata,
                               input int delay, input bit early);
    int          idx;
    bit          exp_hit;
    logic [7:0]  exp_data;
    int          cyc;
    int          waited;
    bit          got;
    bit          saw_req;
    bit          ack_sent;

    idx      = int'(addr[5:0]);
    exp_hit  = line_ok[idx] && (line_addr[idx] == addr);
    exp_data = exp_hit ? line_byte[idx] : mem_model[addr];

    if (!early) @(negedge clk);
    bus.valid         = 1'b1;
    bus.rw            = is_load;
    bus.address_cache = addr;
    tb_wdata          = sdata;
    tb_drive          = !is_load;
    if (early) begin
      @(negedge clk);
      checkOutput("holdoff_busy", 32'(bus.busy), 32'd0);
    end
    @(posedge clk);

    cyc = 0; waited = 0; got = 0; saw_req = 0; ack_sent = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'($urandom);
      if (bus.gnt) begin
        got = 1;
        checkOutput("hit", 32'(bus.hit), 32'(exp_hit));
        checkOutput("latency", 32'(cyc), (is_load && exp_hit) ? 32'd2 : 32'(3 + delay));
        checkOutput("mem_req_after_ack", 32'(bus.mem_req), 32'd0);
        checkOutput("mem_used", 32'(saw_req), 32'(!(is_load && exp_hit)));
        if (is_load) checkOutput("load_data", 32'(data_cache), 32'(exp_data));
      end else if (bus.mem_req && !ack_sent) begin
        if (!saw_req) begin
          saw_req = 1;
          checkOutput("mem_addr", 32'(bus.mem_addr), 32'(addr));
          checkOutput("mem_we", 32'(bus.mem_we), 32'(!is_load));
          if (!is_load) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(sdata));
        end
        if (waited == delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_model[addr];
          ack_sent      = 1;
        end else begin
          waited++;
        end
      end
    end

    bus.valid   = 1'b0;
    tb_drive    = 1'b0;
    bus.mem_ack = 1'b0;

    if (!got) begin
      checkOutput("gnt_timeout", 32'd0, 32'd1);
      resetDut();
    end else begin
      if (is_load && !exp_hit) begin
        line_ok[idx]   = 1'b1;
        line_addr[idx] = addr;
        line_byte[idx] = mem_model[addr];
      end
      if (!is_load) begin
        mem_model[addr] = sdata;
        if (exp_hit) line_byte[idx] = sdata;
      end
      if (exp_hit) exp_hits++; else exp_misses++;
      @(negedge clk);
      checkOutput("gnt_one_cycle", 32'(bus.gnt), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    num_vectors     = 0;
    num_miscompares = 0;
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'($urandom);
    mem_model[12'h123] = 8'hA5;
    mem_model[12'h523] = 8'h77;

    resetDut();
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_hit", 32'(bus.hit), 32'd0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);

    $display("[TB] directed scenarios");
    applyStimulus(1'b1, 12'h123, 8'h00, 1, 1'b0);
    applyStimulus(1'b1, 12'h123, 8'h00, 0, 1'b0);
    applyStimulus(1'b0, 12'h123, 8'h3C, 0, 1'b0);
    applyStimulus(1'b1, 12'h123, 8'h00, 0, 1'b1);
    applyStimulus(1'b1, 12'h523, 8'h00, 2, 1'b0);
    applyStimulus(1'b1, 12'h123, 8'h00, 0, 1'b0);
    applyStimulus(1'b0, 12'h7FF, 8'h11, 1, 1'b0);
    applyStimulus(1'b1, 12'h7FF, 8'h00, 0, 1'b0);

    // Reset in the middle of a refill must abandon it and invalidate the cache.
    bus.valid         = 1'b1;
    bus.rw            = 1'b1;
    bus.address_cache = 12'h0A5;
    for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clk);
    checkOutput("midrst_reached_mem_rd", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("midrst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clearModel();
`ifdef DCACHE_STATS_EN
    checkOutput("midrst_hit_count", 32'(hit_count), 32'd0);
    checkOutput("midrst_miss_count", 32'(miss_count), 32'd0);
`endif
    applyStimulus(1'b1, 12'h123, 8'h00, 0, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      logic [11:0] ra;
      ra = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
      applyStimulus(1'($urandom_range(0, 1)), ra, 8'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

`ifdef DCACHE_STATS_EN
    checkOutput("hit_count", 32'(hit_count), 32'(exp_hits));
    checkOutput("miss_count", 32'(miss_count), 32'(exp_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
